apb_slave_mem: RTL
==================

// Module: apb_slave_mem
// PURPOSE
//   Parametrised APB slave: word-addressed register memory with programmable wait
//   states and error response. Successor to the fixed zero-wait, read-only bench slave.
//   Serves as the bench-side responder for APB_master and as a reusable RTL slave.
//   Adds writes, wait-state insertion, PSLVERR on out-of-range or protocol error.
// PARAMETERS
//   DATA_WIDTH   32  width of PWDATA/PRDATA and of each memory word
//   ADDR_WIDTH   8   width of PADDR; PADDR is a word index (no byte offset)
//   DEPTH        8   number of words; valid addresses 0..DEPTH-1 (DEPTH <= 2**ADDR_WIDTH)
//   WAIT_STATES  0   access-phase cycles with PREADY low before completion (0..15)
// PORTS
//   clk      in   1           clock, all state updates on rising edge
//   rst      in   1           synchronous, active-high reset
//   PSEL     in   1           slave select
//   PEN      in   1           enable (access phase)
//   PW       in   1           1 = write, 0 = read
//   PADDR    in   ADDR_WIDTH  word address
//   PWDATA   in   DATA_WIDTH  write data
//   PREADY   out  1           transfer complete this cycle
//   PRDATA   out  DATA_WIDTH  read data, valid when PREADY & !PW & !PSLVERR
//   PSLVERR  out  1           error response, valid only when PREADY
// BEHAVIOUR
//   Reset (rst=1 at a clk edge): state=IDLE, wait counter=0, all DEPTH words=0.
//     Outputs during/after reset: PREADY=0, PSLVERR=0, PRDATA=0.
//   FSM states: IDLE, SETUP, ACCESS.
//     IDLE:   PSEL & !PEN -> SETUP; PSEL & PEN -> protocol error (below); else IDLE.
//     SETUP:  PSEL & PEN -> ACCESS (cnt=0); PSEL & !PEN -> SETUP; !PSEL -> IDLE.
//     ACCESS: !PSEL or !PEN (master abort) -> IDLE, cnt=0, no write, no PREADY.
//             cnt < WAIT_STATES: PREADY=0, cnt++.
//             cnt == WAIT_STATES: PREADY=1 (combinational from state+cnt), transfer done;
//             next state: PSEL & !PEN -> SETUP, else IDLE; cnt=0.
//   Latency: PREADY rises in the (WAIT_STATES+1)-th cycle of the access phase;
//     WAIT_STATES=0 -> PREADY in first PSEL&PEN cycle (matches legacy bench slave).
//   Range check: PADDR >= DEPTH -> PSLVERR=1 with PREADY; write ignored, PRDATA=0.
//   Write: committed at the clk edge where PSEL&PEN&PREADY&PW&!PSLVERR; mem[PADDR]<=PWDATA.
//   Read: PRDATA = mem[PADDR] combinationally when PREADY&!PW&!PSLVERR, else 0.
//     Read of address written in the previous transfer returns the new value.
//   Protocol error: PSEL&PEN seen in IDLE (no setup cycle, incl. PEN held high after
//     completion): PREADY=1, PSLVERR=1 for that cycle, no write, PRDATA=0, stay IDLE.
//   PSLVERR=0 whenever PREADY=0.
//   PADDR/PW/PWDATA sampled during the completing cycle; changes while waiting are
//     master errors and are not tracked.
//   Reset mid-transfer: transfer discarded, no write, memory cleared, IDLE next cycle.
//   Memory contents persist across transfers; only rst clears them.
// TESTING
//   1. WAIT_STATES=0: write 32'hcafecafe to addr 2, read addr 2 -> PREADY in 1st PEN
//      cycle, PRDATA=32'hcafecafe, PSLVERR=0.
//   2. WAIT_STATES=3: read addr 5 after write 32'h12345678 -> PREADY low 3 access cycles,
//      high on 4th, PRDATA=32'h12345678.
//   3. Out-of-range: write addr 8 (DEPTH=8) then read addr 8 -> both PSLVERR=1 with
//      PREADY; read returns 0; subsequent reads of addrs 0..7 unchanged.
//   4. Protocol error: PSEL&PEN asserted from IDLE with PW=1 addr 1 -> PREADY=1,
//      PSLVERR=1 same cycle; read addr 1 afterwards returns 0.
//   5. Abort: WAIT_STATES=2, write addr 3, drop PSEL after 1 access cycle -> no PREADY,
//      read addr 3 returns 0; next transfer completes normally.
//   6. Reset mid-access: assert rst during wait of a write to addr 4 after addr 4 held
//      32'hdeadbeef -> PREADY=0 next cycle, read addr 4 returns 0.

Source files
------------

// File: rtl/apb_slave_mem.sv
// APB slave with a word-addressed register memory, programmable wait states
// and PSLVERR on out-of-range addresses or a missing setup phase.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no transfer in progress; PSEL&PEN here is a protocol error
// SETUP  | setup cycle seen; a PSEL&PEN cycle here is access cycle 1 (cnt=0)
// ACCESS | later access cycles, cnt counts cycles already spent waiting
module apb_slave_mem #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  PSEL,
    input  logic                  PEN,
    input  logic                  PW,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR
);

    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]        WAIT_CNT = 4'(WAIT_STATES);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    logic             xfer_en;
    logic             addr_ok;
    logic             done;
    logic             proto_err;
    logic             wr_en;
    logic [IDX_W-1:0] idx;

    assign xfer_en = PSEL & PEN;
    assign addr_ok = ({1'b0, PADDR} < DEPTH_L);
    assign idx     = PADDR[IDX_W-1:0];

    // Next-state and wait counter. The first access cycle is evaluated while
    // still in SETUP so that zero wait states complete in the first PEN cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done      = 1'b0;
        proto_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 4'd0;
                if (xfer_en) begin
                    proto_err = 1'b1;
                end else if (PSEL) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP, ST_ACCESS: begin
                if (xfer_en) begin
                    if (cnt_q == WAIT_CNT) begin
                        done  = 1'b1;
                        cnt_d = 4'd0;
                        // PEN is high in the completing cycle, so a new setup
                        // phase can only start from IDLE.
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        state_d = ST_ACCESS;
                    end
                end else if ((state_q == ST_SETUP) && PSEL) begin
                    state_d = ST_SETUP;
                    cnt_d   = 4'd0;
                end else begin
                    // Deselect, or PEN dropped mid-access: master abort.
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Response outputs; forced quiet while reset is asserted.
    always_comb begin
        PREADY  = ~rst & (done | proto_err);
        PSLVERR = ~rst & (proto_err | (done & ~addr_ok));
        wr_en   = ~rst & done & PW & addr_ok;
        PRDATA  = '0;
        if (~rst && done && ~PW && addr_ok) begin
            PRDATA = mem_q[idx];
        end
    end

    // Memory write path: only a clean, completing write updates a word.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_en) begin
            mem_d[idx] = PWDATA;
        end
    end

    // State, counter and memory registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule
